// File: rtl/contador_vai_vem_alvo_pkg.sv
// Shared types and width helpers for the vai/vem position counter.
package contador_vai_vem_alvo_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    MOVENDO = 2'd1,
    CHEGOU  = 2'd2
  } estado_t;

  // One spare bit so Q+PASSO and Q+M-PASSO never overflow before comparison.
  function automatic int larg_ext(input int n);
    return n + 1;
  endfunction

  function automatic int larg_tick(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/contador_vai_vem_alvo_tick.sv
// Modulo-DIV step timer: counts while enabled, o_wrap is high on the cycle the count is DIV-1.
module contador_tick
  import contador_vai_vem_alvo_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic zera_s,
  input  logic i_limpa,
  input  logic i_habilita,
  output logic o_wrap
);

  localparam int            NT    = larg_tick(DIV);
  localparam logic [NT-1:0] C_ULT = NT'(DIV - 1);

  logic [NT-1:0] r_cnt;

  assign o_wrap = i_habilita && (r_cnt == C_ULT);

  always_ff @(posedge clock) begin
    if (zera_s || i_limpa) begin
      r_cnt <= '0;
    end else if (i_habilita) begin
      r_cnt <= (r_cnt == C_ULT) ? '0 : r_cnt + NT'(1);
    end
  end

endmodule

// File: rtl/contador_vai_vem_alvo.sv
// Up/down position counter with manual vai/vem/set_pos and a timed ramp toward alvo (ocupado/pronto).
// Optional wrap of manual steps when CONTADOR_VAI_VEM_ALVO_CIRC_EN is defined (adds the circular port).
module contador_vai_vem_alvo
  import contador_vai_vem_alvo_pkg::*;
#(
  parameter int M     = 100,
  parameter int N     = 7,
  parameter int PASSO = 1,
  parameter int DIV   = 4
) (
  input  logic         clock,
  input  logic         zera_s,
  input  logic         set_pos,
  input  logic [N-1:0] D,
  input  logic         vai,
  input  logic         vem,
  input  logic         ir,
  input  logic [N-1:0] alvo,
  input  logic         cancela,
`ifdef CONTADOR_VAI_VEM_ALVO_CIRC_EN
  input  logic         circular,
`endif
  output logic [N-1:0] Q,
  output logic         inicio,
  output logic         meio,
  output logic         fim,
  output logic         ocupado,
  output logic         pronto
);

  localparam int            NE      = larg_ext(N);
  localparam logic [NE-1:0] C_M     = NE'(M);
  localparam logic [NE-1:0] C_MAX   = NE'(M - 1);
  localparam logic [NE-1:0] C_PASSO = NE'(PASSO);
  localparam logic [N-1:0]  C_MAX_N = N'(M - 1);
  localparam logic [N-1:0]  C_MEIO  = N'(M / 2 - 1);

  estado_t      r_estado, w_estado_prox;
  logic [N-1:0] r_q, w_q_prox;
  logic [N-1:0] r_alvo, w_alvo_prox;
  logic         w_limpa_tick, w_wrap, w_circ;

  logic [NE-1:0] w_q_ext, w_tgt_ext, w_soma, w_dist, w_passo_auto;
  logic [N-1:0]  w_d_cl, w_alvo_cl, w_cima, w_baixo, w_auto;

`ifdef CONTADOR_VAI_VEM_ALVO_CIRC_EN
  assign w_circ = circular;
`else
  assign w_circ = 1'b0;
`endif

  assign w_q_ext   = {1'b0, r_q};
  assign w_tgt_ext = {1'b0, r_alvo};
  assign w_d_cl    = ({1'b0, D}    > C_MAX) ? C_MAX_N : D;
  assign w_alvo_cl = ({1'b0, alvo} > C_MAX) ? C_MAX_N : alvo;

  assign w_soma  = w_q_ext + C_PASSO;
  assign w_cima  = N'((w_soma > C_MAX) ? (w_circ ? w_soma - C_M : C_MAX) : w_soma);
  assign w_baixo = N'((w_q_ext < C_PASSO) ? (w_circ ? w_q_ext + C_M - C_PASSO : '0)
                                          : w_q_ext - C_PASSO);

  // Automatic steps are clipped to the remaining distance so they land exactly.
  assign w_dist       = (w_tgt_ext > w_q_ext) ? w_tgt_ext - w_q_ext : w_q_ext - w_tgt_ext;
  assign w_passo_auto = (w_dist < C_PASSO) ? w_dist : C_PASSO;
  assign w_auto       = N'((w_tgt_ext > w_q_ext) ? w_q_ext + w_passo_auto
                                                 : w_q_ext - w_passo_auto);

  contador_tick #(.DIV(DIV)) u_tick (
    .clock      (clock),
    .zera_s     (zera_s),
    .i_limpa    (w_limpa_tick),
    .i_habilita (r_estado == MOVENDO),
    .o_wrap     (w_wrap)
  );

  always_ff @(posedge clock) begin
    if (zera_s) begin
      r_estado <= OCIOSO;
      r_q      <= '0;
      r_alvo   <= '0;
    end else begin
      r_estado <= w_estado_prox;
      r_q      <= w_q_prox;
      r_alvo   <= w_alvo_prox;
    end
  end

  always_comb begin
    w_estado_prox = r_estado;
    w_q_prox      = r_q;
    w_alvo_prox   = r_alvo;
    w_limpa_tick  = 1'b0;
    if (set_pos) begin
      w_estado_prox = OCIOSO;
      w_q_prox      = w_d_cl;
    end else if (cancela) begin
      w_estado_prox = OCIOSO;
    end else if (ir) begin
      w_alvo_prox = w_alvo_cl;
      if (r_estado != MOVENDO) begin
        if (w_alvo_cl == r_q) begin
          w_estado_prox = CHEGOU;
        end else begin
          w_estado_prox = MOVENDO;
          w_limpa_tick  = 1'b1;
        end
      end
    end else if (r_estado == MOVENDO) begin
      // Arrival is seen one edge after the landing step, giving pronto its documented latency.
      if (r_q == r_alvo) begin
        w_estado_prox = CHEGOU;
      end else if (w_wrap) begin
        w_q_prox = w_auto;
      end
    end else begin
      w_estado_prox = OCIOSO;
      if (vai) begin
        w_q_prox = w_cima;
      end else if (vem) begin
        w_q_prox = w_baixo;
      end
    end
  end

  always_comb begin
    ocupado = (r_estado == MOVENDO);
    pronto  = (r_estado == CHEGOU);
  end

  assign Q      = r_q;
  assign inicio = (r_q == '0);
  assign meio   = (r_q == C_MEIO);
  assign fim    = (r_q == C_MAX_N);

endmodule

// File: tb/tb_contador_vai_vem_alvo.sv
// Bench for contador_vai_vem_alvo: three instances (PASSO/DIV = 1/4, 3/2, 2/1) against a behavioural model.
module tb_contador_vai_vem_alvo;

  localparam int M = 100;
  localparam int N = 7;
`ifdef CONTADOR_VAI_VEM_ALVO_CIRC_EN
  localparam bit CIRC = 1'b1;
`else
  localparam bit CIRC = 1'b0;
`endif

  logic         clock;
  logic         zera_s, set_pos, vai, vem, ir, cancela, circular;
  logic [N-1:0] D, alvo;

  logic [N-1:0] q_o [3];
  logic         oc_o [3];
  logic         pr_o [3];
  logic         in_o [3];
  logic         me_o [3];
  logic         fi_o [3];

  int n_cmp = 0;
  int n_err = 0;

  // Model state: position, target, mode (0 idle, 1 moving, 2 arrived), edges spent moving.
  int mq [3];
  int ma [3];
  int mst [3];
  int mel [3];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  contador_vai_vem_alvo #(.M(M), .N(N), .PASSO(1), .DIV(4)) u_a (
    .clock(clock), .zera_s(zera_s), .set_pos(set_pos), .D(D), .vai(vai), .vem(vem),
    .ir(ir), .alvo(alvo), .cancela(cancela),
`ifdef CONTADOR_VAI_VEM_ALVO_CIRC_EN
    .circular(circular),
`endif
    .Q(q_o[0]), .inicio(in_o[0]), .meio(me_o[0]), .fim(fi_o[0]),
    .ocupado(oc_o[0]), .pronto(pr_o[0]));

  contador_vai_vem_alvo #(.M(M), .N(N), .PASSO(3), .DIV(2)) u_b (
    .clock(clock), .zera_s(zera_s), .set_pos(set_pos), .D(D), .vai(vai), .vem(vem),
    .ir(ir), .alvo(alvo), .cancela(cancela),
`ifdef CONTADOR_VAI_VEM_ALVO_CIRC_EN
    .circular(circular),
`endif
    .Q(q_o[1]), .inicio(in_o[1]), .meio(me_o[1]), .fim(fi_o[1]),
    .ocupado(oc_o[1]), .pronto(pr_o[1]));

  contador_vai_vem_alvo #(.M(M), .N(N), .PASSO(2), .DIV(1)) u_c (
    .clock(clock), .zera_s(zera_s), .set_pos(set_pos), .D(D), .vai(vai), .vem(vem),
    .ir(ir), .alvo(alvo), .cancela(cancela),
`ifdef CONTADOR_VAI_VEM_ALVO_CIRC_EN
    .circular(circular),
`endif
    .Q(q_o[2]), .inicio(in_o[2]), .meio(me_o[2]), .fim(fi_o[2]),
    .ocupado(oc_o[2]), .pronto(pr_o[2]));

  function automatic int passo_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int div_of(input int k);
    case (k)
      0:       return 4;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // One clock edge of the specified behaviour, applied with the inputs currently driven.
  task automatic model_edge();
    int  p, dv, t;
    bit  ce;
    ce = CIRC && circular;
    for (int k = 0; k < 3; k++) begin
      p  = passo_of(k);
      dv = div_of(k);
      if (zera_s) begin
        mq[k] = 0; ma[k] = 0; mst[k] = 0; mel[k] = 0;
      end else if (set_pos) begin
        mq[k]  = min2(int'(D), M - 1);
        mst[k] = 0;
      end else if (cancela) begin
        mst[k] = 0;
      end else if (ir) begin
        t     = min2(int'(alvo), M - 1);
        ma[k] = t;
        if (mst[k] == 1) mel[k]++;
        else if (t == mq[k]) mst[k] = 2;
        else begin
          mst[k] = 1;
          mel[k] = 0;
        end
      end else if (mst[k] == 1) begin
        mel[k]++;
        if (mq[k] == ma[k]) mst[k] = 2;
        else if (mel[k] % dv == 0) begin
          if (ma[k] > mq[k]) mq[k] = mq[k] + min2(p, ma[k] - mq[k]);
          else               mq[k] = mq[k] - min2(p, mq[k] - ma[k]);
        end
      end else begin
        mst[k] = 0;
        if (vai) begin
          if (mq[k] + p <= M - 1) mq[k] = mq[k] + p;
          else                    mq[k] = ce ? mq[k] + p - M : M - 1;
        end else if (vem) begin
          if (mq[k] >= p) mq[k] = mq[k] - p;
          else            mq[k] = ce ? mq[k] + M - p : 0;
        end
      end
    end
  endtask

  task automatic clk_edge();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    zera_s = 0; set_pos = 0; vai = 0; vem = 0; ir = 0; cancela = 0; circular = 0;
    D = '0; alvo = '0;
  endtask

  task automatic test_reset();
    zera_s = 1;
    clk_edge();
    zera_s = 0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (q_o[k] !== 7'd0 || in_o[k] !== 1'b1 || fi_o[k] !== 1'b0 || me_o[k] !== 1'b0 ||
          oc_o[k] !== 1'b0 || pr_o[k] !== 1'b0) begin
        n_err++;
        $display("FAIL reset[%0d]: Q=%0d ini=%b meio=%b fim=%b oc=%b pr=%b, want 0 1 0 0 0 0",
                 k, q_o[k], in_o[k], me_o[k], fi_o[k], oc_o[k], pr_o[k]);
      end
    end
  endtask

  task automatic test_vai_saturate();
    zera_s = 1; clk_edge(); zera_s = 0;
    vai = 1;
    for (int i = 1; i <= 100; i++) begin
      clk_edge();
      if (i == 49) begin
        n_cmp++;
        if (q_o[0] !== 7'd49 || me_o[0] !== 1'b1) begin
          n_err++;
          $display("FAIL vai_meio: Q=%0d meio=%b, want 49 1", q_o[0], me_o[0]);
        end
      end
      if (i >= 99) begin
        n_cmp++;
        if (q_o[0] !== 7'd99 || fi_o[0] !== 1'b1) begin
          n_err++;
          $display("FAIL vai_sat step %0d: Q=%0d fim=%b, want 99 1", i, q_o[0], fi_o[0]);
        end
      end
    end
    vai = 0;
  endtask

  task automatic test_vem_passo3();
    int exp_q [4];
    exp_q = '{7, 4, 1, 0};
    set_pos = 1; D = 7'd10; clk_edge(); set_pos = 0;
    vem = 1;
    for (int i = 0; i < 4; i++) begin
      clk_edge();
      n_cmp++;
      if (int'(q_o[1]) != exp_q[i]) begin
        n_err++;
        $display("FAIL vem_passo3 #%0d: Q=%0d, want %0d", i, q_o[1], exp_q[i]);
      end
    end
    vem = 0;
    n_cmp++;
    if (in_o[1] !== 1'b1) begin
      n_err++;
      $display("FAIL vem_inicio: inicio=%b, want 1", in_o[1]);
    end
    set_pos = 1; D = 7'd120; clk_edge(); set_pos = 0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (q_o[k] !== 7'd99 || fi_o[k] !== 1'b1) begin
        n_err++;
        $display("FAIL set_pos_clamp[%0d]: Q=%0d fim=%b, want 99 1", k, q_o[k], fi_o[k]);
      end
    end
  endtask

  task automatic test_auto_move();
    int eq;
    set_pos = 1; D = 7'd10; clk_edge(); set_pos = 0;
    ir = 1; alvo = 7'd13; clk_edge(); ir = 0;
    n_cmp++;
    if (oc_o[0] !== 1'b1 || q_o[0] !== 7'd10) begin
      n_err++;
      $display("FAIL auto_start: oc=%b Q=%0d, want 1 10", oc_o[0], q_o[0]);
    end
    vai = 1;
    for (int e = 1; e <= 13; e++) begin
      clk_edge();
      eq = min2(10 + e / 4, 13);
      n_cmp++;
      if (int'(q_o[0]) != eq || pr_o[0] !== (e == 13) || oc_o[0] !== (e < 13)) begin
        n_err++;
        $display("FAIL auto_move +%0d: Q=%0d pr=%b oc=%b, want %0d %b %b",
                 e, q_o[0], pr_o[0], oc_o[0], eq, (e == 13), (e < 13));
      end
    end
    vai = 0;
    clk_edge();
    n_cmp++;
    if (q_o[0] !== 7'd13 || pr_o[0] !== 1'b0 || oc_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL auto_after: Q=%0d pr=%b oc=%b, want 13 0 0", q_o[0], pr_o[0], oc_o[0]);
    end
  endtask

  task automatic test_cancela();
    set_pos = 1; D = 7'd50; clk_edge(); set_pos = 0;
    ir = 1; alvo = 7'd60; clk_edge(); ir = 0;
    for (int e = 1; e <= 8; e++) clk_edge();
    cancela = 1; clk_edge(); cancela = 0;
    n_cmp++;
    if (q_o[0] !== 7'd52 || oc_o[0] !== 1'b0 || pr_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL cancela: Q=%0d oc=%b pr=%b, want 52 0 0", q_o[0], oc_o[0], pr_o[0]);
    end
    clk_edge();
    n_cmp++;
    if (q_o[0] !== 7'd52 || pr_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL cancela_hold: Q=%0d pr=%b, want 52 0", q_o[0], pr_o[0]);
    end
    ir = 1; alvo = 7'd52; clk_edge(); ir = 0;
    n_cmp++;
    if (pr_o[0] !== 1'b1 || oc_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL ir_same: pr=%b oc=%b, want 1 0", pr_o[0], oc_o[0]);
    end
    clk_edge();
    n_cmp++;
    if (pr_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL ir_same_pulse: pr=%b, want 0", pr_o[0]);
    end
  endtask

  task automatic test_retarget();
    int eq;
    set_pos = 1; D = 7'd20; clk_edge(); set_pos = 0;
    ir = 1; alvo = 7'd30; clk_edge(); ir = 0;
    for (int e = 1; e <= 17; e++) begin
      ir   = (e == 6);
      alvo = 7'd18;
      clk_edge();
      ir = 0;
      eq = (e < 4) ? 20 : (e < 8) ? 21 : (e < 12) ? 20 : (e < 16) ? 19 : 18;
      n_cmp++;
      if (int'(q_o[0]) != eq || pr_o[0] !== (e == 17) || oc_o[0] !== (e < 17)) begin
        n_err++;
        $display("FAIL retarget +%0d: Q=%0d pr=%b oc=%b, want %0d %b %b",
                 e, q_o[0], pr_o[0], oc_o[0], eq, (e == 17), (e < 17));
      end
    end
    ir = 1; alvo = 7'd90; clk_edge(); ir = 0;
    for (int e = 0; e < 5; e++) clk_edge();
    zera_s = 1; clk_edge(); zera_s = 0;
    n_cmp++;
    if (q_o[0] !== 7'd0 || oc_o[0] !== 1'b0 || pr_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL zera_mid: Q=%0d oc=%b pr=%b, want 0 0 0", q_o[0], oc_o[0], pr_o[0]);
    end
    clk_edge();
    n_cmp++;
    if (pr_o[0] !== 1'b0 || oc_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL zera_after: pr=%b oc=%b, want 0 0", pr_o[0], oc_o[0]);
    end
  endtask

`ifdef CONTADOR_VAI_VEM_ALVO_CIRC_EN
  task automatic test_circular();
    circular = 1;
    set_pos = 1; D = 7'd98; clk_edge(); set_pos = 0;
    vai = 1; clk_edge(); vai = 0;
    n_cmp++;
    if (q_o[2] !== 7'd0) begin
      n_err++;
      $display("FAIL circ_vai: Q=%0d, want 0", q_o[2]);
    end
    set_pos = 1; D = 7'd1; clk_edge(); set_pos = 0;
    vem = 1; clk_edge(); vem = 0;
    n_cmp++;
    if (q_o[2] !== 7'd99) begin
      n_err++;
      $display("FAIL circ_vem: Q=%0d, want 99", q_o[2]);
    end
    circular = 0;
    set_pos = 1; D = 7'd98; clk_edge(); set_pos = 0;
    vai = 1; clk_edge(); vai = 0;
    n_cmp++;
    if (q_o[2] !== 7'd99) begin
      n_err++;
      $display("FAIL circ_off: Q=%0d, want 99", q_o[2]);
    end
  endtask
`endif

  task automatic test_random();
    int printed = 0;
    for (int c = 0; c < 3000; c++) begin
      zera_s   = ($urandom_range(0, 199) == 0);
      set_pos  = ($urandom_range(0, 29) == 0);
      cancela  = ($urandom_range(0, 39) == 0);
      ir       = ($urandom_range(0, 14) == 0);
      vai      = ($urandom_range(0, 3) == 0);
      vem      = ($urandom_range(0, 3) == 0);
      D        = 7'($urandom_range(0, 127));
      alvo     = 7'($urandom_range(0, 127));
      circular = CIRC ? 1'($urandom_range(0, 1)) : 1'b0;
      if (cancela) begin
        ir = 0; vai = 0; vem = 0;
      end
      clk_edge();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (int'(q_o[k]) != mq[k] || oc_o[k] !== (mst[k] == 1) || pr_o[k] !== (mst[k] == 2) ||
            in_o[k] !== (mq[k] == 0) || me_o[k] !== (mq[k] == M / 2 - 1) ||
            fi_o[k] !== (mq[k] == M - 1)) begin
          n_err++;
          if (printed < 30) begin
            printed++;
            $display("FAIL random[%0d] cyc %0d: Q=%0d oc=%b pr=%b, want %0d %b %b",
                     k, c, q_o[k], oc_o[k], pr_o[k], mq[k], (mst[k] == 1), (mst[k] == 2));
          end
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      mq[k] = 0; ma[k] = 0; mst[k] = 0; mel[k] = 0;
    end
    #2;
    test_reset();
    test_vai_saturate();
    test_vem_passo3();
    test_auto_move();
    test_cancela();
    test_retarget();
`ifdef CONTADOR_VAI_VEM_ALVO_CIRC_EN
    test_circular();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
